// File: rtl/mining_pkg.sv
// Shared widths, frame geometry and serialiser state encoding for the hit readout path.
`default_nettype none

package mining_pkg;
   localparam int HASH_W        = 256;
   localparam int NONCE_W       = 32;
   localparam int WORD_W        = 32;
   localparam int WORDS_PER_HIT = 1 + HASH_W / WORD_W;
   localparam int ENTRY_W       = NONCE_W + HASH_W;
   localparam int IDX_W         = $clog2(WORDS_PER_HIT);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Entry is {nonce, hash}; word 0 is the nonce, then the hash MS word first.
   function automatic logic [WORD_W-1:0] entry_word(input logic [ENTRY_W-1:0] e,
                                                    input logic [IDX_W-1:0]   idx);
      logic [ENTRY_W-1:0] s;
      s = e >> ((WORDS_PER_HIT - 1 - int'(idx)) * WORD_W);
      return s[WORD_W-1:0];
   endfunction
endpackage

`default_nettype wire

// File: rtl/hit_reporter_if.sv
// Hit capture and host word-stream bundle; slave = hit_reporter, master = its environment.
`default_nettype none

interface hit_reporter_if #(parameter int DEPTH = 4);
   import mining_pkg::*;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic               hit_valid;
   logic [HASH_W-1:0]  hit_hash;
   logic [NONCE_W-1:0] hit_nonce;
   logic               hit_ready;
   logic               tx_valid;
   logic [WORD_W-1:0]  tx_data;
   logic               tx_last;
   logic               tx_ready;
   logic [CNT_W-1:0]   fifo_count;
   logic               overflow;
   logic               clr_overflow;

   modport slave (
      input  hit_valid, hit_hash, hit_nonce, tx_ready, clr_overflow,
      output hit_ready, tx_valid, tx_data, tx_last, fifo_count, overflow
   );

   modport master (
      output hit_valid, hit_hash, hit_nonce, tx_ready, clr_overflow,
      input  hit_ready, tx_valid, tx_data, tx_last, fifo_count, overflow
   );
endinterface

`default_nettype wire

// File: rtl/hit_fifo.sv
// Synchronous FIFO of hit entries; exposes the head and the entry behind it for gapless framing.
`default_nettype none

module hit_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 288,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_head,
   output logic [WIDTH-1:0] o_next,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;
   logic [AW-1:0]    w_rd_next;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign w_push    = i_push && !o_full;
   assign w_pop     = i_pop && !o_empty;
   assign w_rd_next = r_rd_ptr + AW'(1);
   assign o_head    = r_mem[r_rd_ptr];
   assign o_next    = r_mem[w_rd_next];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= w_rd_next;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: rtl/hit_reporter.sv
// Queues winning hits and serialises each as a nonce + hash word frame to the host.
`default_nettype none

module hit_reporter
   import mining_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   hit_reporter_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WORDS_PER_HIT - 1);

   logic [ENTRY_W-1:0] w_head;
   logic [ENTRY_W-1:0] w_next;
   logic               w_full;
   logic               w_empty;
   logic [CW-1:0]      w_count;
   logic               w_push;
   logic               w_drop;
   logic               w_pop;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic               r_tx_valid;
   logic [WORD_W-1:0]  r_tx_data;
   logic               r_tx_last;
   logic               r_overflow;

   assign w_push = bus.hit_valid && !w_full;
   assign w_drop = bus.hit_valid && w_full;
   assign w_pop  = (r_state == SEND) && bus.tx_ready && (r_idx == c_last_idx);

   hit_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  ({bus.hit_nonce, bus.hit_hash}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_next  (w_next),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign bus.hit_ready  = !w_full;
   assign bus.fifo_count = w_count;
   assign bus.tx_valid   = r_tx_valid;
   assign bus.tx_data    = r_tx_data;
   assign bus.tx_last    = r_tx_last;
   assign bus.overflow   = r_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
         r_tx_last  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_drop)                r_overflow <= 1'b1;
         else if (bus.clr_overflow) r_overflow <= 1'b0;

         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_state    <= SEND;
                  r_idx      <= '0;
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= entry_word(w_head, '0);
                  r_tx_last  <= 1'b0;
               end
            end
            SEND: begin
               if (bus.tx_ready) begin
                  if (r_idx == c_last_idx) begin
                     r_idx <= '0;
                     // Entry behind the head is already stored, so the next frame starts without a bubble.
                     if (w_count > CW'(1)) begin
                        r_tx_data <= entry_word(w_next, '0);
                        r_tx_last <= 1'b0;
                     end else begin
                        r_state    <= IDLE;
                        r_tx_valid <= 1'b0;
                        r_tx_last  <= 1'b0;
                     end
                  end else begin
                     r_idx     <= r_idx + IDX_W'(1);
                     r_tx_data <= entry_word(w_head, r_idx + IDX_W'(1));
                     r_tx_last <= (r_idx + IDX_W'(1)) == c_last_idx;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_hit_reporter.sv
// Directed bench for hit_reporter: framing, backpressure, back-to-back, overflow, reset.
`default_nettype none

module tb_hit_reporter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;
   int   first_valid;

   logic [31:0]  exp_n [$];
   logic [255:0] exp_h [$];

   always #5 clk = ~clk;

   hit_reporter_if #(.DEPTH(4)) bus ();

   hit_reporter #(.DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [255:0] mk_hash(input logic [31:0] seed);
      logic [255:0] h;
      for (int k = 0; k < 8; k++) h[255-32*k -: 32] = seed ^ (32'h01010101 * k);
      return h;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] n, input logic [255:0] h, input int k);
      if (k == 0) return n;
      return h[255-32*(k-1) -: 32];
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      bus.hit_valid = 1'b0;
      bus.hit_hash = '0;
      bus.hit_nonce = '0;
      bus.tx_ready = 1'b0;
      bus.clr_overflow = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Call at a negedge; returns at the negedge after the accepting edge.
   task automatic send_hit(input logic [31:0] n, input logic [255:0] h);
      bus.hit_valid = 1'b1;
      bus.hit_nonce = n;
      bus.hit_hash = h;
      @(negedge clk);
      bus.hit_valid = 1'b0;
   endtask

   task automatic queue_hit(input logic [31:0] n, input logic [255:0] h);
      exp_n.push_back(n);
      exp_h.push_back(h);
   endtask

   // Receives nframes frames from exp_n/exp_h; bp selects the 1,0,0,1 ready pattern.
   task automatic consume(input int nframes, input bit bp);
      bit [3:0] pat = 4'b1001;
      int k = 0, f = 0, cyc = 0, hs = 0, gaps = 0;
      bit started = 0, rdy, pend = 0;
      int pend_cnt = 0;
      first_valid = -1;
      while (f < nframes && cyc < 40 * nframes + 20) begin
         @(negedge clk);
         cyc++;
         if (pend) begin
            check("count_after_frame", 64'(bus.fifo_count), 64'(pend_cnt));
            pend = 0;
         end
         rdy = bp ? pat[cyc % 4] : 1'b1;
         bus.tx_ready = rdy;
         if (bus.tx_valid) begin
            if (!started) first_valid = cyc;
            started = 1;
            check("tx_data", 64'(bus.tx_data), 64'(exp_word(exp_n[f], exp_h[f], k)));
            check("tx_last", 64'(bus.tx_last), 64'(k == 8));
            if (rdy) begin
               hs++;
               if (k == 8) begin
                  k = 0;
                  f++;
                  pend = 1;
                  pend_cnt = nframes - f;
               end else k++;
            end
         end else if (started) gaps++;
      end
      check("frames_done", 64'(f), 64'(nframes));
      check("handshakes", 64'(hs), 64'(9 * nframes));
      check("no_bubble", 64'(gaps), 64'(0));
      @(negedge clk);
      if (pend) check("count_after_frame", 64'(bus.fifo_count), 64'(pend_cnt));
      check("idle_after", 64'(bus.tx_valid), 64'(0));
      bus.tx_ready = 1'b0;
      exp_n.delete();
      exp_h.delete();
   endtask

   task automatic clr_ovf();
      bus.clr_overflow = 1'b1;
      @(negedge clk);
      bus.clr_overflow = 1'b0;
      check("ovf_cleared", 64'(bus.overflow), 64'(0));
   endtask

   logic [255:0] h1;

   initial begin
      for (int k = 0; k < 8; k++) h1[255-32*k -: 32] = 32'h11111111 * k;
      do_reset();
      check("rst_tx_valid", 64'(bus.tx_valid), 64'(0));
      check("rst_tx_data", 64'(bus.tx_data), 64'(0));
      check("rst_tx_last", 64'(bus.tx_last), 64'(0));
      check("rst_count", 64'(bus.fifo_count), 64'(0));
      check("rst_overflow", 64'(bus.overflow), 64'(0));
      check("rst_hit_ready", 64'(bus.hit_ready), 64'(1));

      // Single hit, latency and framing
      queue_hit(32'hDEADBEEF, h1);
      send_hit(32'hDEADBEEF, h1);
      check("t1_count", 64'(bus.fifo_count), 64'(1));
      check("t1_not_yet_valid", 64'(bus.tx_valid), 64'(0));
      consume(1, 0);
      check("t1_latency", 64'(first_valid), 64'(1));

      // Backpressure
      queue_hit(32'hDEADBEEF, h1);
      send_hit(32'hDEADBEEF, h1);
      consume(1, 1);

      // Three back-to-back hits, ready held high
      for (int i = 0; i < 3; i++) queue_hit(32'hA0000000 + i, mk_hash(32'h100 + i));
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               send_hit(32'hA0000000 + i, mk_hash(32'h100 + i));
               check("t3_count_up", 64'(bus.fifo_count), 64'(i + 1));
            end
         end
         consume(3, 0);
      join

      // Overflow with host stalled
      for (int i = 0; i < 5; i++) begin
         check("t4_hit_ready", 64'(bus.hit_ready), 64'(i < 4));
         if (i < 4) queue_hit(32'hB0000000 + i, mk_hash(32'h200 + i));
         bus.hit_valid = 1'b1;
         bus.hit_nonce = 32'hB0000000 + i;
         bus.hit_hash = mk_hash(32'h200 + i);
         @(negedge clk);
      end
      bus.hit_valid = 1'b0;
      check("t4_overflow", 64'(bus.overflow), 64'(1));
      check("t4_count_full", 64'(bus.fifo_count), 64'(4));
      consume(4, 0);
      clr_ovf();
      for (int i = 0; i < 4; i++) begin
         queue_hit(32'hC0000000 + i, mk_hash(32'h300 + i));
         send_hit(32'hC0000000 + i, mk_hash(32'h300 + i));
      end
      bus.hit_valid = 1'b1;
      bus.clr_overflow = 1'b1;
      bus.hit_nonce = 32'hC0000009;
      @(negedge clk);
      bus.hit_valid = 1'b0;
      bus.clr_overflow = 1'b0;
      check("t4_set_wins", 64'(bus.overflow), 64'(1));
      consume(4, 0);

      // Push on the pop cycle while full
      clr_ovf();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) queue_hit(32'hD0000000 + i, mk_hash(32'h400 + i));
         send_hit(32'hD0000000 + i, mk_hash(32'h400 + i));
      end
      for (int k = 0; k < 9; k++) begin
         check("t6_word", 64'(bus.tx_data), 64'(exp_word(32'hD0000000, mk_hash(32'h400), k)));
         if (k == 8) begin
            check("t6_last", 64'(bus.tx_last), 64'(1));
            check("t6_hit_ready", 64'(bus.hit_ready), 64'(0));
            bus.hit_valid = 1'b1;
            bus.hit_nonce = 32'hD00000FF;
            bus.hit_hash = mk_hash(32'h4FF);
         end
         bus.tx_ready = 1'b1;
         @(negedge clk);
      end
      bus.hit_valid = 1'b0;
      bus.tx_ready = 1'b0;
      check("t6_overflow", 64'(bus.overflow), 64'(1));
      check("t6_count", 64'(bus.fifo_count), 64'(3));
      check("t6_next_word0", 64'(bus.tx_data), 64'(32'hD0000001));
      consume(3, 0);

      // Asynchronous reset during word 4 (overflow still set from above)
      check("t5_ovf_before", 64'(bus.overflow), 64'(1));
      bus.tx_ready = 1'b1;
      send_hit(32'hE0000000, mk_hash(32'h500));
      for (int t = 0; t < 5 && !bus.tx_valid; t++) @(negedge clk);
      repeat (4) @(negedge clk);
      check("t5_word4", 64'(bus.tx_data), 64'(exp_word(32'hE0000000, mk_hash(32'h500), 4)));
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 64'(bus.tx_valid), 64'(0));
      check("t5_rst_count", 64'(bus.fifo_count), 64'(0));
      check("t5_rst_ovf", 64'(bus.overflow), 64'(0));
      check("t5_rst_ready", 64'(bus.hit_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      bus.tx_ready = 1'b0;
      @(negedge clk);
      queue_hit(32'hF0000001, mk_hash(32'h600));
      send_hit(32'hF0000001, mk_hash(32'h600));
      consume(1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

`default_nettype wire
